// File: rtl/counter_seq_pkg.sv
// Shared encodings for the command-driven counter sequencer: command opcodes,
// sequencer states and count-direction values.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_LOAD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_seq_if.sv
// Command port of the counter sequencer.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// the sink holds cmd_ready high at all times, so every valid cycle is one command.
interface counter_seq_if #(
  parameter int N = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic         cmd_dir;
  logic [N-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_dir,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_dir,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/updown_counter_core.sv
// N-bit up/down counter datapath; load has priority over enable and the count
// wraps modulo 2^N in both directions.
module updown_counter_core
  import counter_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         dir,
  output logic [N-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer: accepts START/STOP/LOAD, steps the counter core once
// per clock in RUN and pulses done when the stepped value reaches the limit.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int N           = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  counter_seq_if.slave   cmd,
  output logic [N-1:0]   count,
  output logic           busy,
  output logic           done,
  output logic           err,
  output state_t         dbg_state
);

  state_t       state_q, state_n;
  logic [N-1:0] limit_q, base_q;
  logic         dir_q;
  logic         done_q, done_n;
  logic         err_q, err_n;
  logic         arm;
  logic         core_en, core_load;
  logic [N-1:0] load_val;
  logic [N-1:0] stepped;
  logic         is_start, is_stop, is_load;

  assign cmd.cmd_ready = 1'b1;
  assign is_start = cmd.cmd_valid && (cmd.cmd_op == OP_START);
  assign is_stop  = cmd.cmd_valid && (cmd.cmd_op == OP_STOP);
  assign is_load  = cmd.cmd_valid && (cmd.cmd_op == OP_LOAD);

  // Value the core would produce on a plain step; used for the limit compare.
  assign stepped = (dir_q == DIR_UP) ? count + 1'b1 : count - 1'b1;

  always_comb begin
    state_n   = state_q;
    core_en   = 1'b0;
    core_load = 1'b0;
    load_val  = cmd.cmd_data;
    done_n    = 1'b0;
    err_n     = 1'b0;
    arm       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (is_stop) begin
          state_n = ST_PAUSE;
        end else begin
          err_n = is_start || is_load;
          // In auto-reload mode the step after a limit hit restores the base.
          if (AUTO_RELOAD && done_q) begin
            core_load = 1'b1;
            load_val  = base_q;
          end else begin
            core_en = 1'b1;
            if (stepped == limit_q) begin
              done_n = 1'b1;
              if (!AUTO_RELOAD) state_n = ST_DONE;
            end
          end
        end
      end
      default: begin
        if (is_load) begin
          core_load = 1'b1;
        end else if (is_start) begin
          arm     = 1'b1;
          state_n = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      limit_q <= '1;
      base_q  <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      done_q  <= done_n;
      err_q   <= err_n;
      if (arm) begin
        limit_q <= cmd.cmd_data;
        dir_q   <= cmd.cmd_dir;
        base_q  <= count;
      end
    end
  end

  updown_counter_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (core_en),
    .load     (core_load),
    .load_val (load_val),
    .dir      (dir_q),
    .count    (count)
  );

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: one instance without auto-reload and one
// with auto-reload, checked against hand-computed count/done sequences.
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] count_a, count_b;
  logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
  state_t     st_a, st_b;

  int n_vec = 0;
  int n_bad = 0;

  // Each entry is {done, count} expected after one clock.
  logic [8:0] exp_q[$];

  counter_seq_if #(.N(8)) cif_a ();
  counter_seq_if #(.N(8)) cif_b ();

  counter_seq_ctrl #(.N(8), .AUTO_RELOAD(1'b0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif_a.slave),
    .count     (count_a),
    .busy      (busy_a),
    .done      (done_a),
    .err       (err_a),
    .dbg_state (st_a)
  );

  counter_seq_ctrl #(.N(8), .AUTO_RELOAD(1'b1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif_b.slave),
    .count     (count_b),
    .busy      (busy_b),
    .done      (done_b),
    .err       (err_b),
    .dbg_state (st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cmd_set(input bit unit_b, input logic [1:0] op, input logic dir,
                         input logic [7:0] data);
    if (!unit_b) begin
      cif_a.cmd_valid = 1'b1; cif_a.cmd_op = op; cif_a.cmd_dir = dir; cif_a.cmd_data = data;
    end else begin
      cif_b.cmd_valid = 1'b1; cif_b.cmd_op = op; cif_b.cmd_dir = dir; cif_b.cmd_data = data;
    end
  endtask

  task automatic cmd_clr();
    cif_a.cmd_valid = 1'b0; cif_a.cmd_op = OP_NOP; cif_a.cmd_dir = 1'b0; cif_a.cmd_data = 8'h00;
    cif_b.cmd_valid = 1'b0; cif_b.cmd_op = OP_NOP; cif_b.cmd_dir = 1'b0; cif_b.cmd_data = 8'h00;
  endtask

  // One-cycle command: applied for exactly one rising edge.
  task automatic send(input bit unit_b, input logic [1:0] op, input logic dir,
                      input logic [7:0] data);
    cmd_set(unit_b, op, dir, data);
    tick();
    cmd_clr();
  endtask

  // scoreboard: drain exp_q one clock per entry
  task automatic run_expect(input bit unit_b, input string tag);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      if (!unit_b) check(tag, {23'd0, done_a, count_a}, {23'd0, e});
      else         check(tag, {23'd0, done_b, count_b}, {23'd0, e});
    end
  endtask

  initial begin
    cmd_clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_count", {24'd0, count_a}, 32'h00);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_done",  {31'd0, done_a}, 32'd0);
    check("rst_err",   {31'd0, err_a}, 32'd0);
    check("rst_state", {30'd0, st_a}, {30'd0, ST_IDLE});
    check("rst_ready", {31'd0, cif_a.cmd_ready}, 32'd1);

    // STOP in IDLE: no effect, no err
    send(1'b0, OP_STOP, 1'b0, 8'h00);
    check("idle_stop_err", {31'd0, err_a}, 32'd0);

    // 1: up count 10 -> 14
    send(1'b0, OP_LOAD, 1'b0, 8'h10);
    check("t1_load", {24'd0, count_a}, 32'h10);
    send(1'b0, OP_START, DIR_UP, 8'h14);
    check("t1_arm_count", {24'd0, count_a}, 32'h10);
    check("t1_arm_busy", {31'd0, busy_a}, 32'd1);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h12});
    exp_q.push_back({1'b0, 8'h13});
    exp_q.push_back({1'b1, 8'h14});
    exp_q.push_back({1'b0, 8'h14});
    exp_q.push_back({1'b0, 8'h14});
    run_expect(1'b0, "t1_seq");
    check("t1_busy_after", {31'd0, busy_a}, 32'd0);
    check("t1_state", {30'd0, st_a}, {30'd0, ST_DONE});

    // 2: down count with wrap
    send(1'b0, OP_LOAD, 1'b0, 8'h02);
    send(1'b0, OP_START, DIR_DOWN, 8'hFE);
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b1, 8'hFE});
    exp_q.push_back({1'b0, 8'hFE});
    run_expect(1'b0, "t2_seq");

    // 4: STOP at 20, LOAD in PAUSE, restart
    send(1'b0, OP_LOAD, 1'b0, 8'h00);
    send(1'b0, OP_START, DIR_UP, 8'h40);
    for (int i = 0; i < 32; i++) tick();
    check("t4_pre_stop", {24'd0, count_a}, 32'h20);
    send(1'b0, OP_STOP, 1'b0, 8'h00);
    check("t4_stop_count", {24'd0, count_a}, 32'h20);
    check("t4_stop_busy", {31'd0, busy_a}, 32'd0);
    check("t4_stop_state", {30'd0, st_a}, {30'd0, ST_PAUSE});
    tick();
    check("t4_hold", {24'd0, count_a}, 32'h20);
    send(1'b0, OP_LOAD, 1'b0, 8'h3E);
    check("t4_pause_load", {24'd0, count_a}, 32'h3E);
    send(1'b0, OP_START, DIR_UP, 8'h40);
    exp_q.push_back({1'b0, 8'h3F});
    exp_q.push_back({1'b1, 8'h40});
    run_expect(1'b0, "t4_seq");

    // 5: illegal commands in RUN, limit preserved
    send(1'b0, OP_START, DIR_UP, 8'h45);
    tick();
    check("t5_run", {24'd0, count_a}, 32'h41);
    send(1'b0, OP_LOAD, 1'b0, 8'h00);
    check("t5_load_count", {24'd0, count_a}, 32'h42);
    check("t5_load_err", {31'd0, err_a}, 32'd1);
    tick();
    check("t5_err_clear", {31'd0, err_a}, 32'd0);
    check("t5_step", {24'd0, count_a}, 32'h43);
    send(1'b0, OP_START, DIR_DOWN, 8'h44);
    check("t5_start_err", {31'd0, err_a}, 32'd1);
    check("t5_start_done", {31'd0, done_a}, 32'd0);
    check("t5_start_count", {24'd0, count_a}, 32'h44);
    tick();
    check("t5_limit_kept", {23'd0, done_a, count_a}, {23'd0, 1'b1, 8'h45});
    check("t5_err_once", {31'd0, err_a}, 32'd0);
    // STOP colliding with the terminal step
    send(1'b0, OP_START, DIR_UP, 8'h47);
    tick();
    check("t5_pre", {24'd0, count_a}, 32'h46);
    send(1'b0, OP_STOP, 1'b0, 8'h00);
    check("t5_stop_done", {31'd0, done_a}, 32'd0);
    check("t5_stop_count", {24'd0, count_a}, 32'h46);
    check("t5_stop_state", {30'd0, st_a}, {30'd0, ST_PAUSE});
    tick();
    check("t5_stop_done2", {31'd0, done_a}, 32'd0);

    // 6: reset mid-RUN, same-cycle command ignored
    send(1'b0, OP_LOAD, 1'b0, 8'h30);
    send(1'b0, OP_START, DIR_UP, 8'hFF);
    tick(); tick(); tick();
    check("t6_pre", {24'd0, count_a}, 32'h33);
    rst = 1'b1;
    cmd_set(1'b0, OP_LOAD, 1'b0, 8'h77);
    tick();
    rst = 1'b0;
    cmd_clr();
    check("t6_count", {24'd0, count_a}, 32'h00);
    check("t6_busy", {31'd0, busy_a}, 32'd0);
    check("t6_done", {31'd0, done_a}, 32'd0);
    check("t6_state", {30'd0, st_a}, {30'd0, ST_IDLE});
    tick();
    check("t6_cmd_ignored", {24'd0, count_a}, 32'h00);

    // 3: auto-reload instance, done every 3 cycles
    send(1'b1, OP_LOAD, 1'b0, 8'h05);
    send(1'b1, OP_START, DIR_UP, 8'h07);
    check("t3_arm", {24'd0, count_b}, 32'h05);
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b1, 8'h07});
    exp_q.push_back({1'b0, 8'h05});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b1, 8'h07});
    exp_q.push_back({1'b0, 8'h05});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b1, 8'h07});
    run_expect(1'b1, "t3_seq");
    check("t3_busy", {31'd0, busy_b}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
